// File: rtl/bytecode_fetch_if.sv
// rtl/bytecode_fetch_if.sv - consumer and bytecode RAM signals of the byte-fetch stage
interface bytecode_fetch_if #(
    parameter int ADDRESS_WIDTH = 16
);
    logic                       start;
    logic                       pc_reset;
    logic                       pc_load;
    logic [ADDRESS_WIDTH-1:0]   pc_load_value;
    logic [7:0]                 next_byte;
    logic                       ready;
    logic                       busy;
    logic [ADDRESS_WIDTH-1:0]   pc;
    logic                       error;
    logic [ADDRESS_WIDTH-3:0]   mem_addr;
    logic                       mem_rd_en;
    logic [31:0]                mem_rdata;

    modport master (
        input  start, pc_reset, pc_load, pc_load_value, mem_rdata,
        output next_byte, ready, busy, pc, error, mem_addr, mem_rd_en
    );

    modport slave (
        output start, pc_reset, pc_load, pc_load_value, mem_rdata,
        input  next_byte, ready, busy, pc, error, mem_addr, mem_rd_en
    );
endinterface

// File: rtl/bytecode_fetch.sv
// rtl/bytecode_fetch.sv - JVM bytecode byte server with one-word line buffer and branch-loadable PC
module bytecode_fetch #(
    parameter int                       SIZE          = 1024,
    parameter int                       ADDRESS_WIDTH = 16,
    parameter logic [ADDRESS_WIDTH-1:0] PC_START      = '0
) (
    input  logic                clk,
    input  logic                rst,
    bytecode_fetch_if.master    fetch_if
);
    localparam int AW = ADDRESS_WIDTH;
    localparam logic [AW:0] SIZE_LIM = (AW+1)'(SIZE);

    typedef enum logic [1:0] {IDLE, MEM_REQ, MEM_WAIT} state_t;

    state_t         state_q;
    logic [AW-1:0]  pc_q;
    logic [7:0]     next_byte_q;
    logic           ready_q;
    logic           busy_q;
    logic           error_q;
    logic [AW-3:0]  mem_addr_q;
    logic           mem_rd_en_q;
    logic [31:0]    line_q;
    logic [AW-3:0]  tag_q;
    logic           valid_q;

    logic [AW-1:0]  addr_d;
    logic           oob_d;
    logic           hit_d;

    // JVM bytecode is big-endian: byte 0 of a word sits in the top lane
    function automatic logic [7:0] select_byte(input logic [31:0] w, input logic [1:0] sel);
        case (sel)
            2'd0:    select_byte = w[31:24];
            2'd1:    select_byte = w[23:16];
            2'd2:    select_byte = w[15:8];
            default: select_byte = w[7:0];
        endcase
    endfunction

    always_comb begin
        addr_d = fetch_if.pc_load ? fetch_if.pc_load_value : pc_q;
        oob_d  = {1'b0, addr_d} >= SIZE_LIM;
        hit_d  = valid_q && (tag_q == addr_d[AW-1:2]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            pc_q        <= PC_START;
            next_byte_q <= 8'h00;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
            error_q     <= 1'b0;
            mem_addr_q  <= '0;
            mem_rd_en_q <= 1'b0;
            line_q      <= '0;
            tag_q       <= '0;
            valid_q     <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            if (!fetch_if.pc_reset) begin
                pc_q        <= PC_START;
                valid_q     <= 1'b0;
                error_q     <= 1'b0;
                state_q     <= IDLE;
                busy_q      <= 1'b0;
                mem_rd_en_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        // a start coinciding with the ready pulse belongs to the finished request
                        if (fetch_if.start && !ready_q) begin
                            if (oob_d) begin
                                next_byte_q <= 8'h00;
                                ready_q     <= 1'b1;
                                error_q     <= 1'b1;
                            end else if (hit_d) begin
                                next_byte_q <= select_byte(line_q, addr_d[1:0]);
                                ready_q     <= 1'b1;
                                pc_q        <= addr_d + AW'(1);
                            end else begin
                                mem_addr_q  <= addr_d[AW-1:2];
                                mem_rd_en_q <= 1'b1;
                                pc_q        <= addr_d;
                                state_q     <= MEM_REQ;
                                busy_q      <= 1'b1;
                            end
                        end else if (fetch_if.pc_load) begin
                            pc_q <= fetch_if.pc_load_value;
                        end
                    end
                    MEM_REQ: begin
                        mem_rd_en_q <= 1'b0;
                        state_q     <= MEM_WAIT;
                    end
                    MEM_WAIT: begin
                        line_q      <= fetch_if.mem_rdata;
                        tag_q       <= mem_addr_q;
                        valid_q     <= 1'b1;
                        next_byte_q <= select_byte(fetch_if.mem_rdata, pc_q[1:0]);
                        ready_q     <= 1'b1;
                        pc_q        <= pc_q + AW'(1);
                        state_q     <= IDLE;
                        busy_q      <= 1'b0;
                    end
                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign fetch_if.next_byte = next_byte_q;
    assign fetch_if.ready     = ready_q;
    assign fetch_if.busy      = busy_q;
    assign fetch_if.pc        = pc_q;
    assign fetch_if.error     = error_q;
    assign fetch_if.mem_addr  = mem_addr_q;
    assign fetch_if.mem_rd_en = mem_rd_en_q;
endmodule

// File: tb/tb_bytecode_fetch.sv
// tb/tb_bytecode_fetch.sv - randomized self-checking bench for bytecode_fetch
module tb_bytecode_fetch;
    localparam int AW   = 16;
    localparam int SIZE = 64;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bytecode_fetch_if #(.ADDRESS_WIDTH(AW)) bus ();

    bytecode_fetch #(.SIZE(SIZE), .ADDRESS_WIDTH(AW), .PC_START(16'd0)) dut (
        .clk      (clk),
        .rst      (rst),
        .fetch_if (bus)
    );

    logic [31:0] ram [0:15];
    always @(posedge clk) if (bus.mem_rd_en) bus.mem_rdata <= ram[bus.mem_addr[3:0]];

    int n_checks = 0;
    int n_fail   = 0;

    int          m_pc;
    bit          m_valid;
    int          m_word;
    bit          m_err;
    logic [7:0]  m_byte;

    int          lat, el;
    logic [7:0]  b, eb;
    bit          rd, er, extra;

    task automatic model_reset(input bit full);
        m_pc = 0; m_valid = 0; m_err = 0;
        if (full) m_byte = 8'h00;
    endtask

    task automatic model_fetch(input bit load, input int lv, output int e_lat, output logic [7:0] e_b, output bit e_rd);
        int a;
        bit hit;
        a = load ? lv : m_pc;
        if (a >= SIZE) begin
            e_lat = 1; e_b = 8'h00; e_rd = 0; m_err = 1;
        end else begin
            hit    = m_valid && (m_word == a / 4);
            e_lat  = hit ? 1 : 3;
            e_rd   = !hit;
            e_b    = 8'((ram[a / 4] >> (8 * (3 - a % 4))) & 32'hFF);
            m_valid = 1; m_word = a / 4;
            m_pc   = (a + 1) % 65536;
        end
        m_byte = e_b;
    endtask

    task automatic drive_fetch(input bit load, input int lv, output int o_lat, output logic [7:0] o_b, output bit o_rd, output bit o_extra);
        bus.start = 1'b1; bus.pc_load = load; bus.pc_load_value = 16'(lv);
        @(negedge clk);
        bus.start = 1'b0; bus.pc_load = 1'b0;
        o_lat = 1; o_rd = 0;
        while (bus.ready !== 1'b1 && o_lat < 12) begin
            o_rd = o_rd | (bus.mem_rd_en === 1'b1);
            @(negedge clk);
            o_lat++;
        end
        o_b = bus.next_byte;
        @(negedge clk);
        o_extra = (bus.ready === 1'b1);
    endtask

    task automatic pulse_pc_reset();
        bus.pc_reset = 1'b0;
        @(negedge clk);
        bus.pc_reset = 1'b1;
        model_reset(0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 0; bus.pc_reset = 1; bus.pc_load = 0; bus.pc_load_value = '0;
        model_reset(1);
        @(negedge clk);
        n_checks++; if (bus.pc !== 16'd0) begin n_fail++; $display("FAIL reset_pc got %0d want 0", bus.pc); end
        n_checks++; if ({bus.ready, bus.busy, bus.error, bus.mem_rd_en} !== 4'b0) begin n_fail++; $display("FAIL reset_flags got %b want 0000", {bus.ready, bus.busy, bus.error, bus.mem_rd_en}); end
        n_checks++; if (bus.next_byte !== 8'h00 || bus.mem_addr !== '0) begin n_fail++; $display("FAIL reset_data byte %h addr %h want 0", bus.next_byte, bus.mem_addr); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_miss_then_hits();
        pulse_pc_reset();
        for (int i = 0; i < 4; i++) begin
            model_fetch(0, 0, el, eb, er);
            drive_fetch(0, 0, lat, b, rd, extra);
            n_checks++; if (lat !== el) begin n_fail++; $display("FAIL line%0d latency got %0d want %0d", i, lat, el); end
            n_checks++; if (b !== eb) begin n_fail++; $display("FAIL line%0d byte got %h want %h", i, b, eb); end
            n_checks++; if (rd !== er) begin n_fail++; $display("FAIL line%0d rd_en got %0d want %0d", i, rd, er); end
            n_checks++; if (bus.pc !== 16'(m_pc) || extra) begin n_fail++; $display("FAIL line%0d pc got %0d want %0d extra_ready %0d", i, bus.pc, m_pc, extra); end
        end
    endtask

    task automatic test_word_cross();
        bus.pc_load = 1; bus.pc_load_value = 16'd3;
        @(negedge clk);
        bus.pc_load = 0; m_pc = 3;
        n_checks++; if (bus.pc !== 16'd3) begin n_fail++; $display("FAIL load_only pc got %0d want 3", bus.pc); end
        for (int i = 0; i < 2; i++) begin
            model_fetch(0, 0, el, eb, er);
            drive_fetch(0, 0, lat, b, rd, extra);
            n_checks++; if (lat !== el || rd !== er) begin n_fail++; $display("FAIL cross%0d latency %0d rd %0d want %0d %0d", i, lat, rd, el, er); end
            n_checks++; if (b !== eb || bus.pc !== 16'(m_pc)) begin n_fail++; $display("FAIL cross%0d byte %h pc %0d want %h %0d", i, b, bus.pc, eb, m_pc); end
        end
        n_checks++; if (bus.mem_addr !== 14'd1) begin n_fail++; $display("FAIL cross mem_addr got %0d want 1", bus.mem_addr); end
    endtask

    task automatic test_pc_load();
        model_fetch(1, 9, el, eb, er);
        drive_fetch(1, 9, lat, b, rd, extra);
        n_checks++; if (lat !== el || rd !== er || bus.mem_addr !== 14'd2) begin n_fail++; $display("FAIL branch latency %0d rd %0d addr %0d want %0d %0d 2", lat, rd, bus.mem_addr, el, er); end
        n_checks++; if (b !== eb || bus.pc !== 16'd10) begin n_fail++; $display("FAIL branch byte %h pc %0d want %h 10", b, bus.pc, eb); end
        model_fetch(1, 20, el, eb, er);
        bus.start = 1; bus.pc_load = 1; bus.pc_load_value = 16'd20;
        @(negedge clk);
        bus.start = 0; bus.pc_load_value = 16'd40;
        n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL busy_flag got %b want 1", bus.busy); end
        @(negedge clk);
        bus.pc_load = 0;
        lat = 2;
        while (bus.ready !== 1'b1 && lat < 12) begin @(negedge clk); lat++; end
        n_checks++; if (lat !== el || bus.next_byte !== eb) begin n_fail++; $display("FAIL busy_load latency %0d byte %h want %0d %h", lat, bus.next_byte, el, eb); end
        n_checks++; if (bus.pc !== 16'(m_pc)) begin n_fail++; $display("FAIL busy_load pc got %0d want %0d", bus.pc, m_pc); end
        @(negedge clk);
    endtask

    task automatic test_error();
        int lvs [4] = '{SIZE, 0, 63, 0};
        bit lds [4] = '{1, 0, 1, 0};
        for (int i = 0; i < 4; i++) begin
            model_fetch(lds[i], lvs[i], el, eb, er);
            drive_fetch(lds[i], lvs[i], lat, b, rd, extra);
            n_checks++; if (lat !== el || rd !== er) begin n_fail++; $display("FAIL err%0d latency %0d rd %0d want %0d %0d", i, lat, rd, el, er); end
            n_checks++; if (b !== eb || bus.pc !== 16'(m_pc)) begin n_fail++; $display("FAIL err%0d byte %h pc %0d want %h %0d", i, b, bus.pc, eb, m_pc); end
            n_checks++; if (bus.error !== m_err) begin n_fail++; $display("FAIL err%0d error got %b want %b", i, bus.error, m_err); end
        end
        pulse_pc_reset();
        n_checks++; if (bus.pc !== 16'd0 || bus.error !== 1'b0) begin n_fail++; $display("FAIL err_clear pc %0d error %b want 0 0", bus.pc, bus.error); end
    endtask

    task automatic test_abort();
        int seen;
        pulse_pc_reset();
        bus.start = 1;
        @(negedge clk);
        bus.start = 0;
        @(negedge clk);
        bus.pc_reset = 0;
        @(negedge clk);
        bus.pc_reset = 1;
        model_reset(0);
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            seen += int'(bus.ready === 1'b1);
            @(negedge clk);
        end
        n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL abort ready pulses got %0d want 0", seen); end
        n_checks++; if (bus.pc !== 16'd0 || bus.busy !== 1'b0 || bus.next_byte !== m_byte) begin n_fail++; $display("FAIL abort pc %0d busy %b byte %h want 0 0 %h", bus.pc, bus.busy, bus.next_byte, m_byte); end
        model_fetch(0, 0, el, eb, er);
        drive_fetch(0, 0, lat, b, rd, extra);
        n_checks++; if (lat !== el || rd !== er || b !== eb) begin n_fail++; $display("FAIL abort_refetch latency %0d rd %0d byte %h want %0d %0d %h", lat, rd, b, el, er, eb); end
    endtask

    task automatic test_async_reset_and_held_start();
        int seen;
        bus.start = 1; bus.pc_load = 1; bus.pc_load_value = 16'd32;
        @(negedge clk);
        bus.start = 0; bus.pc_load = 0;
        #2 rst = 1'b1;
        #1;
        model_reset(1);
        n_checks++; if ({bus.busy, bus.ready, bus.mem_rd_en, bus.error} !== 4'b0) begin n_fail++; $display("FAIL async_rst flags got %b want 0000", {bus.busy, bus.ready, bus.mem_rd_en, bus.error}); end
        n_checks++; if (bus.pc !== 16'd0 || bus.next_byte !== 8'h00) begin n_fail++; $display("FAIL async_rst pc %0d byte %h want 0 00", bus.pc, bus.next_byte); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        model_fetch(0, 0, el, eb, er);
        bus.start = 1;
        seen = 0; lat = 0;
        while (seen == 0 && lat < 12) begin
            @(negedge clk);
            lat++;
            if (bus.ready === 1'b1) begin seen++; b = bus.next_byte; end
        end
        bus.start = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            seen += int'(bus.ready === 1'b1);
        end
        n_checks++; if (seen !== 1) begin n_fail++; $display("FAIL held_start ready pulses got %0d want 1", seen); end
        n_checks++; if (lat !== el || b !== eb || bus.pc !== 16'(m_pc)) begin n_fail++; $display("FAIL held_start latency %0d byte %h pc %0d want %0d %h %0d", lat, b, bus.pc, el, eb, m_pc); end
    endtask

    task automatic test_random();
        int r, lv;
        bit ld;
        for (int i = 0; i < 80; i++) begin
            r = $urandom_range(0, 11);
            if (r == 0) begin
                pulse_pc_reset();
                n_checks++; if (bus.pc !== 16'd0 || bus.error !== 1'b0) begin n_fail++; $display("FAIL rnd%0d pc_reset pc %0d error %b", i, bus.pc, bus.error); end
            end else begin
                ld = (r < 5);
                lv = $urandom_range(0, SIZE + 3);
                model_fetch(ld, lv, el, eb, er);
                drive_fetch(ld, lv, lat, b, rd, extra);
                n_checks++; if (lat !== el || rd !== er || extra) begin n_fail++; $display("FAIL rnd%0d latency %0d rd %0d extra %0d want %0d %0d 0", i, lat, rd, extra, el, er); end
                n_checks++; if (b !== eb) begin n_fail++; $display("FAIL rnd%0d byte got %h want %h", i, b, eb); end
                n_checks++; if (bus.pc !== 16'(m_pc) || bus.error !== m_err) begin n_fail++; $display("FAIL rnd%0d pc %0d error %b want %0d %b", i, bus.pc, bus.error, m_pc, m_err); end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) ram[i] = $urandom;
        ram[0] = 32'hB200_0212;
        test_reset();
        test_miss_then_hits();
        test_word_cross();
        test_pc_load();
        test_error();
        test_abort();
        test_async_reset_and_held_start();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end
endmodule
